// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator and single-outstanding instruction-bus initiator.
// Latency: data_ok at cycle N -> validF at N+1; consumption at M -> new request at M+1.
// Backpressure: stallF holds the buffered instruction; requests are never withdrawn, so
// a request in flight at redirect time is drained and its response discarded.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   stallF, flushF       : hazard-unit hold / drop of the buffered instruction
//   jump/jump_target     : execute-stage redirect (ignored while stallF=1)
//   exception, interrupt_update_pc, trap_vector : trap redirect (highest priority)
//   mret/mepc            : mret redirect
//   ireq_valid/ireq_addr : instruction-bus request
//   iresp_data_ok/iresp_data : instruction-bus response
//   validF/pcF/instrF    : instruction presented to the F->D register
//
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_busy and perf_drop_cnt outputs.
module fetch_pc_unit #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            flushF,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            exception,
  input  logic            interrupt_update_pc,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  output logic            validF,
  output logic [XLEN-1:0] pcF,
  output logic [31:0]     instrF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_busy,
  output logic [31:0]     perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  // Address of the request abandoned by a redirect; the bus must keep seeing it.
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            drop;

  // Redirect selection: trap beats mret beats jump; jump only counts when not stalled.
  logic            trap_redir;
  logic            redir;
  logic [XLEN-1:0] redir_pc;

  always_comb begin
    trap_redir = exception | interrupt_update_pc;
    redir      = trap_redir | mret | (jump & ~stallF);
    if (trap_redir)  redir_pc = trap_vector;
    else if (mret)   redir_pc = mepc;
    else             redir_pc = jump_target;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      buf_pc_q     <= RESET_PC;
      buf_instr_q  <= '0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    drain_addr_d = drain_addr_q;
    drop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redir) pc_d = redir_pc;
      end
      FETCH: begin
        if (redir) begin
          pc_d = redir_pc;
          if (iresp_data_ok) begin
            drop = 1'b1;              // response belongs to the dead path
          end else begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (iresp_data_ok) begin
          buf_pc_d    = pc_q;
          buf_instr_d = iresp_data;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = redir_pc;
          drop    = 1'b1;
          state_d = FETCH;
        end else if (flushF) begin
          // pc still equals buf_pc here, so the same instruction is refetched.
          drop    = 1'b1;
          state_d = FETCH;
        end else if (!stallF) begin
          pc_d    = buf_pc_q + XLEN'(4);
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redir) pc_d = redir_pc;   // latest redirect wins
        if (iresp_data_ok) begin
          drop    = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ireq_valid = (state_q == FETCH) || (state_q == DRAIN);
    ireq_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
    validF     = (state_q == HOLD);
    pcF        = buf_pc_q;
    instrF     = buf_instr_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetch_busy_q, perf_fetch_busy_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_fetch_busy_d = perf_fetch_busy_q;
    perf_drop_cnt_d   = perf_drop_cnt_q;
    if (ireq_valid && !iresp_data_ok) perf_fetch_busy_d = perf_fetch_busy_q + 64'd1;
    if (drop)                         perf_drop_cnt_d   = perf_drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_busy_q <= '0;
      perf_drop_cnt_q   <= '0;
    end else begin
      perf_fetch_busy_q <= perf_fetch_busy_d;
      perf_drop_cnt_q   <= perf_drop_cnt_d;
    end
  end

  assign perf_fetch_busy = perf_fetch_busy_q;
  assign perf_drop_cnt   = perf_drop_cnt_q;
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Fetch-stage PC generator and instruction-bus initiator. It consumes the stall/flush/redirect controls from the pipeline hazard unit (stallF, flushF, jump, exception, mret, interrupt_update_pc) and issues single-outstanding requests on the instruction bus. It buffers one fetched instruction and presents it to the F->D pipeline register. It owns all discard-after-redirect behaviour so that decode never sees an instruction from a dead path.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset
XLEN, 64, PC / target width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stallF  in  1  hold buffered instruction / PC (from hazard)
flushF  in  1  drop buffered instruction (from hazard)
jump  in  1  branch/jump taken redirect (from execute)
jump_target  in  XLEN  jump redirect PC
exception  in  1  trap redirect (writeback)
interrupt_update_pc  in  1  interrupt redirect
trap_vector  in  XLEN  target for exception and interrupt (mtvec)
mret  in  1  mret redirect (writeback)
mepc  in  XLEN  target for mret
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  XLEN  instruction-bus request address
iresp_data_ok  in  1  response valid; completes the request
iresp_data  in  32  fetched instruction
validF  out  1  instrF/pcF hold a live instruction
pcF  out  XLEN  PC of presented instruction
instrF  out  32  presented instruction

Behaviour:
- Internal state: pc (next fetch address), buf_pc, buf_instr, FSM {IDLE, FETCH, HOLD, DRAIN}.
- Reset (async, any time, including mid-request): state=IDLE, pc=RESET_PC. Outstanding bus transaction is abandoned; its response is never seen.
- Reset output values: ireq_valid=0, ireq_addr=RESET_PC, validF=0, pcF=RESET_PC, instrF=0.
- Redirect priority, highest first: (exception|interrupt_update_pc)->trap_vector; mret->mepc; jump->jump_target.
- Trap, interrupt and mret redirects are honoured regardless of stallF. jump is honoured only when stallF=0; jump with stallF=1 is ignored.
- redir = any honoured redirect this cycle; redir_pc = its target. Targets are used unmodified; no alignment check.
- ireq_valid=1 in FETCH and DRAIN.
- ireq_addr=pc in FETCH. In DRAIN it holds the abandoned address until data_ok, because requests may not be withdrawn.
- validF=1 only in HOLD; pcF/instrF = buf_pc/buf_instr. When validF=0, decode receives a bubble.
- IDLE: next cycle -> FETCH. Any redir in IDLE updates pc.
- FETCH:
  - redir & data_ok: pc<=redir_pc, response dropped, stay FETCH.
  - redir & !data_ok: pc<=redir_pc, ->DRAIN.
  - data_ok: buf_pc<=pc, buf_instr<=iresp_data, ->HOLD.
  - Otherwise stay.
- HOLD:
  - redir: drop buffer, pc<=redir_pc, ->FETCH.
  - flushF (any stallF): drop buffer, pc unchanged (refetch same PC), ->FETCH.
  - stallF: stay; outputs stable.
  - Otherwise (consumed): pc<=buf_pc+4, ->FETCH.
- DRAIN:
  - redir: pc<=redir_pc (latest wins), stay until data_ok.
  - data_ok: response dropped, ->FETCH.
- Latency: data_ok at cycle N -> validF=1 at N+1. Consumption at M -> new request issued at M+1. Peak throughput is one instruction per 2 cycles with zero-wait memory.
- pc+4 wraps modulo 2^XLEN.
- Never two outstanding requests. A dropped response never appears on validF.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_busy (64) and perf_drop_cnt (32), both reset to 0.
  - perf_fetch_busy: +1 each cycle with ireq_valid=1 && !iresp_data_ok.
  - perf_drop_cnt: +1 for each dropped response or dropped HOLD buffer.
  - Both wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning 32'h13 -> IDLE 1 cycle; ireq_addr 0x80000000, 0x80000004, 0x80000008 on successive requests; validF pulses with pcF matching.
- data_ok delayed 3 cycles, jump=1 target 0x80000100 on the first wait cycle -> DRAIN; old response dropped (validF stays 0); next request addr 0x80000100.
- HOLD with stallF=1 for 4 cycles -> pcF/instrF constant, ireq_valid=0; stallF drops -> next request at pcF+4.
- HOLD with stallF=1, flushF=1 (csr serialisation) -> buffer dropped, refetch same pcF.
- Same cycle: exception=1 (trap_vector 0x80000200), mret=1, jump=1 -> next addr 0x80000200. In a second case jump=1 with stallF=1 -> ignored.
- Assert reset mid-DRAIN -> outputs return to reset values immediately; fetch restarts at RESET_PC.
